alu_cmd_sequencer: RTL and testbench

- Upstream issue stage for the 4-bit combinational ALU.
- Accepts operation commands {op, a, b} over a valid/ready interface and buffers them in a small FIFO.
- Drives one command at a time onto the ALU operand/opcode inputs and captures the 8-bit ALU result one cycle later.
- Presents each result, with a divide-by-zero error flag, on a valid/ready result interface. Ordering is strictly in-order.

---
 rtl/alu_cmd_sequencer_if.sv | 37 +++
 rtl/alu_cmd_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle for the ALU command sequencer.
// master: command producer / result consumer; slave: the sequencer.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_a,
    output cmd_b,
    output res_ready,
    input  cmd_ready,
    input  res_valid,
    input  res_data,
    input  res_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_a,
    input  cmd_b,
    input  res_ready,
    output cmd_ready,
    output res_valid,
    output res_data,
    output res_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: FIFO-buffered commands, one in flight,
// registered operands, in-order results with divide-by-zero flagging.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.slave   bus,
  output logic [3:0]           alu_op,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  input  logic [7:0]           alu_out,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t           state;
  state_t           state_n;
  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             rdy_en;
  logic             pend_err;
  logic             push;
  logic             pop;
  logic             cap;
  logic             done;
  logic             res_valid_q;
  logic             res_err_q;
  logic [7:0]       res_data_q;

  // rdy_en keeps cmd_ready low through reset and the first edge after it
  assign bus.cmd_ready = rdy_en && (count != FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem[rd_ptr];

  assign bus.res_valid = res_valid_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_data  = res_data_q;

  assign busy = (count != '0) || (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    cap     = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: begin
        cap     = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        if (res_valid_q && bus.res_ready) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      pend_err    <= 1'b0;
      res_data_q  <= 8'h00;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      if (pop) begin
        alu_op   <= head.op;
        alu_a    <= head.a;
        alu_b    <= head.b;
        pend_err <= (head.op == 4'b0011) && (head.b == '0);
      end
      // a zero divisor is reported as all-ones regardless of the ALU
      if (cap) begin
        res_data_q  <= pend_err ? 8'hFF : alu_out;
        res_err_q   <= pend_err;
        res_valid_q <= 1'b1;
      end
      if (done) begin
        res_valid_q <= 1'b0;
        res_err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU.
// Results are collected at handshake and compared to hand-computed values.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] resq [$];

  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(
    .DEPTH (4),
    .PTR_W (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_out (alu_out),
    .busy    (busy)
  );

  // 0 add, 1 sub, 2 mul, 3 div, 4 shift left by b
  always_comb begin
    alu_out = 8'h00;
    case (alu_op)
      4'd0: alu_out = {4'h0, alu_a} + {4'h0, alu_b};
      4'd1: alu_out = {4'h0, alu_a} - {4'h0, alu_b};
      4'd2: alu_out = {4'h0, alu_a} * {4'h0, alu_b};
      4'd3: alu_out = (alu_b != 0) ? {4'h0, alu_a / alu_b} : 8'h00;
      4'd4: alu_out = {4'h0, alu_a} << alu_b;
      default: alu_out = 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      resq.push_back({bus.res_err, bus.res_data});
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [3:0] op, logic [3:0] a, logic [3:0] b);
    logic acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    for (int i = 0; i < 50; i++) begin
      acc = bus.cmd_ready;
      tick();
      if (acc) break;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_res(string tag, int n);
    for (int i = 0; i < 300; i++) begin
      if (resq.size() >= n) break;
      tick();
    end
    chk(tag, resq.size(), n);
  endtask

  task automatic chk_res(string tag, int idx, logic [8:0] exp);
    logic [8:0] v;
    v = (idx < resq.size()) ? resq[idx] : 9'bx;
    chk(tag, {23'h0, v}, {23'h0, exp});
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (!busy && !bus.res_valid) break;
      tick();
    end
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic [3:0] k;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    repeat (3) tick();

    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 8'h00);
    chk("rst_res_err", bus.res_err, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 12'h000);
    chk("rst_busy", busy, 0);

    rst = 1'b0;
    #1;
    chk("rdy_pre_edge", bus.cmd_ready, 0);
    tick();
    chk("rdy_post_edge", bus.cmd_ready, 1);

    // single add with latency check
    bus.res_ready = 1'b1;
    push(4'd0, 4'd3, 4'd5);
    chk("add_n_valid", bus.res_valid, 0);
    tick();
    chk("add_n1_ops", {alu_op, alu_a, alu_b}, 12'h035);
    chk("add_n1_valid", bus.res_valid, 0);
    tick();
    chk("add_n2_valid", bus.res_valid, 1);
    chk("add_n2_data", bus.res_data, 8'h08);
    chk("add_n2_err", bus.res_err, 0);
    tick();
    chk("add_done_valid", bus.res_valid, 0);
    chk("add_done_busy", busy, 0);
    resq.delete();

    // arithmetic sequence
    push(4'd1, 4'd2, 4'd5);
    push(4'd2, 4'd15, 4'd15);
    push(4'd4, 4'd9, 4'd1);
    wait_res("seq_count", 3);
    chk_res("seq_sub", 0, 9'h0FD);
    chk_res("seq_mul", 1, 9'h0E1);
    chk_res("seq_shl", 2, 9'h012);
    drain();
    resq.delete();

    // divide by zero
    push(4'd3, 4'd9, 4'd0);
    push(4'd3, 4'd9, 4'd2);
    wait_res("div_count", 2);
    chk_res("div_zero", 0, 9'h1FF);
    chk_res("div_ok", 1, 9'h004);
    drain();
    resq.delete();

    // backpressure: 5 absorbed, 6th blocked
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    k = 4'd1;
    for (int c = 0; c < 10; c++) begin
      bus.cmd_op = 4'd0;
      bus.cmd_a  = k;
      bus.cmd_b  = 4'd0;
      acc = bus.cmd_ready;
      tick();
      if (acc) k = k + 4'd1;
    end
    chk("bp_accepted", k - 4'd1, 5);
    chk("bp_ready_low", bus.cmd_ready, 0);
    chk("bp_valid", bus.res_valid, 1);
    chk("bp_data", bus.res_data, 8'h01);
    repeat (3) tick();
    chk("bp_hold_data", bus.res_data, 8'h01);
    chk("bp_hold_ready", bus.cmd_ready, 0);
    chk("bp_hold_alu", alu_a, 1);
    bus.res_ready = 1'b1;
    push(4'd0, 4'd6, 4'd0);
    wait_res("bp_count", 6);
    for (int i = 0; i < 6; i++) begin
      chk_res($sformatf("bp_res%0d", i), i, 9'(i + 1));
    end
    drain();
    resq.delete();

    // simultaneous push/pop keeps count, then wrap over 10 commands
    bus.res_ready = 1'b0;
    push(4'd0, 4'd1, 4'd0);
    push(4'd0, 4'd2, 4'd0);
    push(4'd0, 4'd3, 4'd0);
    tick();
    chk("pp_pre_count", dut.count, 2);
    bus.res_ready = 1'b1;
    tick();
    chk("pp_idle_valid", bus.res_valid, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd0;
    bus.cmd_a     = 4'd4;
    bus.cmd_b     = 4'd0;
    tick();
    bus.cmd_valid = 1'b0;
    chk("pp_count", dut.count, 2);
    chk("pp_pop_a", alu_a, 2);
    for (int i = 0; i < 10; i++) begin
      push(4'd0, 4'(i), 4'(i));
    end
    wait_res("wrap_count", 14);
    for (int i = 0; i < 4; i++) begin
      chk_res($sformatf("wrap_pre%0d", i), i, 9'(i + 1));
    end
    for (int i = 0; i < 10; i++) begin
      chk_res($sformatf("wrap_res%0d", i), 4 + i, 9'(2 * i));
    end
    drain();
    resq.delete();

    // reset mid-operation
    bus.res_ready = 1'b0;
    push(4'd0, 4'd1, 4'd2);
    push(4'd0, 4'd2, 4'd2);
    push(4'd0, 4'd3, 4'd2);
    push(4'd0, 4'd4, 4'd2);
    tick();
    chk("mid_pre_valid", bus.res_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", bus.cmd_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    repeat (8) tick();
    chk("mid_no_stale", resq.size(), 0);
    chk("mid_idle_busy", busy, 0);
    push(4'd0, 4'd1, 4'd1);
    wait_res("mid_new_count", 1);
    chk_res("mid_new_add", 0, 9'h002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
